// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared types and default geometry for the icache way RAM.
package sargantana_icache_pkg;

    typedef enum logic {RAM_CLEAR, RAM_IDLE} way_ram_state_t;

    localparam int DEF_N_WAYS    = 4;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_WAY_WIDTH = 256;

endpackage

// File: rtl/sargantana_way_bank.sv
// sargantana_way_bank: synchronous single-port bank; read data holds when not reading.
module sargantana_way_bank #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = (en_i && !we_i) ? mem_q[addr_i] : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    // Storage carries no reset; the top-level clear engine zeroes it.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) mem_q[addr_i] <= data_i;
    end

    assign data_o = rdata_q;

endmodule

// File: rtl/sargantana_icache_way_ram.sv
// sargantana_icache_way_ram: N-way single-port icache array with post-reset/flush clear engine.
// SARGANTANA_ICACHE_RAM_OUTREG_EN adds an output register stage (2-cycle read latency).
module sargantana_icache_way_ram
    import sargantana_icache_pkg::*;
#(
    parameter int N_WAYS     = DEF_N_WAYS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int WAY_WIDTH  = DEF_WAY_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    output logic                          ready_o,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [N_WAYS-1:0]             way_en_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [WAY_WIDTH-1:0]          data_i,
    output logic                          rvalid_o,
    output logic [N_WAYS*WAY_WIDTH-1:0]   data_o
);

    way_ram_state_t          state_d, state_q;
    logic [ADDR_WIDTH-1:0]   cnt_d, cnt_q;
    logic                    rvalid_d, rvalid_q;
    logic [N_WAYS-1:0]       bank_en;
    logic                    bank_we;
    logic [ADDR_WIDTH-1:0]   bank_addr;
    logic [WAY_WIDTH-1:0]    bank_wdata;
    logic [N_WAYS*WAY_WIDTH-1:0] lanes;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rvalid_d   = 1'b0;
        bank_en    = '0;
        bank_we    = 1'b0;
        bank_addr  = addr_i;
        bank_wdata = data_i;
        if (state_q == RAM_CLEAR) begin
            bank_en    = '1;
            bank_we    = 1'b1;
            bank_addr  = cnt_q;
            bank_wdata = '0;
            cnt_d      = (cnt_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
            state_d    = (cnt_q == ADDR_WIDTH'(DEPTH - 1)) ? RAM_IDLE : RAM_CLEAR;
        end else if (flush_i) begin
            state_d = RAM_CLEAR;
            cnt_d   = '0;
        end else if (req_i) begin
            bank_en  = way_en_i;
            bank_we  = we_i;
            rvalid_d = !we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RAM_CLEAR;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ready_o = (state_q == RAM_IDLE);

    for (genvar g = 0; g < N_WAYS; g++) begin : g_way
        sargantana_way_bank #(
            .DEPTH      (DEPTH),
            .WIDTH      (WAY_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (bank_en[g]),
            .we_i   (bank_we),
            .addr_i (bank_addr),
            .data_i (bank_wdata),
            .data_o (lanes[g*WAY_WIDTH +: WAY_WIDTH])
        );
    end

`ifdef SARGANTANA_ICACHE_RAM_OUTREG_EN
    logic [N_WAYS*WAY_WIDTH-1:0] dout_d, dout_q;
    logic                        rvalid2_d, rvalid2_q;

    // Disabled bank lanes already hold the previous read, so a full copy keeps lane-hold intact.
    always_comb begin
        dout_d    = rvalid_q ? lanes : dout_q;
        rvalid2_d = rvalid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q    <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            rvalid2_q <= rvalid2_d;
        end
    end

    assign data_o   = dout_q;
    assign rvalid_o = rvalid2_q;
`else
    assign data_o   = lanes;
    assign rvalid_o = rvalid_q;
`endif

endmodule

// File: doc/sargantana_icache_way_ram.md
# sargantana_icache_way_ram

Multi-way, single-port instruction-cache data/tag array. It replaces per-set RAM instances with one parametrised block holding `N_WAYS` independent way banks that share one address. The block also has a built-in clear engine that zeroes every row after reset and on flush. It sits between the icache controller (lookup reads, refill writes) and the hit/way-select logic.

## Interface
Parameters:
- `N_WAYS`, 4, number of way banks
- `DEPTH`, 64, rows per bank
- `WAY_WIDTH`, 256, bits per way row
- `ADDR_WIDTH`, `$clog2(DEPTH)`, row address width

Ports:
- `clk_i` in 1: clock; all logic on the rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `flush_i` in 1: request a full clear of all rows in all ways
- `ready_o` out 1: array accepts requests; low while clearing
- `req_i` in 1: access request, sampled only when `ready_o`=1
- `we_i` in 1: 1 = write, 0 = read
- `way_en_i` in `N_WAYS`: per-way enable for the access
- `addr_i` in `ADDR_WIDTH`: row address
- `data_i` in `WAY_WIDTH`: write data, replicated to every enabled way
- `rvalid_o` out 1: one-cycle pulse, `data_o` updated by a read
- `data_o` out `N_WAYS*WAY_WIDTH`: way k occupies bits `[k*WAY_WIDTH +: WAY_WIDTH]`

## Operation
- States: CLEAR, IDLE.
- Reset:
  - state=CLEAR, clear counter=0.
  - `ready_o`=0, `rvalid_o`=0, `data_o`=0.
- CLEAR:
  - Each cycle, row `cnt` of every way is written with 0 and `cnt` increments.
  - After row `DEPTH-1` is written, the state moves to IDLE and the counter wraps to 0.
  - `req_i` and `flush_i` are ignored; they are not queued.
- IDLE, `ready_o`=1:
  - `flush_i`=1 enters CLEAR with cnt=0. Flush has priority: a `req_i` in the same cycle is dropped.
  - Else `req_i && we_i`: `data_i` is written to `addr_i` in every way with `way_en_i[k]`=1. Other ways are untouched. No `rvalid_o`.
  - Else `req_i && !we_i`: for each way with `way_en_i[k]`=1, its `data_o` lane is loaded from `addr_i`. Disabled lanes hold their previous value. `rvalid_o` pulses.
  - A request with `way_en_i`=0 performs no write. As a read, it still pulses `rvalid_o`, and all lanes hold.
- Single port: exactly one operation per cycle. A write followed by a read of the same row on the next cycle returns the new data.
- `rst_i` asserted mid-CLEAR or mid-read: the block returns to reset state. The clear restarts from row 0 and any pending `rvalid_o` is cancelled.

## Timing
- Read latency: 1 cycle (request edge N gives `data_o`/`rvalid_o` valid after edge N+1). With the output register enabled, latency is 2.
- Write: takes effect at the request edge.
- Clear: `ready_o` rises exactly `DEPTH` cycles after the first edge with `rst_i`=0, or after the edge that accepted `flush_i`. It is low from the edge after flush acceptance.
- `data_o` is not cleared by a flush. It holds its last read value until the next read.

## Configuration
- `SARGANTANA_ICACHE_RAM_OUTREG_EN` defined:
  - Adds an output register stage on `data_o` and `rvalid_o`, giving 2-cycle read latency.
  - Both registers reset to 0.
  - Lane-hold semantics apply at the final stage.
  - A flush accepted while a read is in the pipe does not cancel that read's `rvalid_o`.
- Not defined: 1-cycle latency as above.

## Structure
- `sargantana_icache_pkg` receives:
  - `typedef enum logic {RAM_CLEAR, RAM_IDLE} way_ram_state_t`
  - default `N_WAYS`/`DEPTH`/`WAY_WIDTH` constants
- Sub-module `sargantana_way_bank`:
  - One synchronous single-port bank with `clk_i`, `rst_i`, `en_i`, `we_i`, `addr_i`, `data_i`, `data_o`, where `data_o` holds when not reading.
  - Instantiated `N_WAYS` times via generate.
  - The top level owns the FSM, the clear counter and address/data muxing.

## Test plan
- Reset then idle, `DEPTH`=64: `ready_o`=0 for 64 cycles, 1 at cycle 64. Reading row 63 of all ways returns 0 and `rvalid_o` pulses once.
- Write `data_i`=0xA5… to row 5 with `way_en_i`=4'b0101, then read row 5 with all ways enabled: lanes 0 and 2 = 0xA5…, lanes 1 and 3 = 0.
- Back-to-back write of row 7 then read of row 7 on the next cycle: read returns the new data at latency 1 (2 with `SARGANTANA_ICACHE_RAM_OUTREG_EN`).
- Read row 3 with `way_en_i`=4'b0001 after lanes hold known values: only lane 0 changes, lanes 1–3 unchanged.
- `flush_i` and `req_i` (write) in the same IDLE cycle: the write is lost, `ready_o` is low for 64 cycles, and all rows read 0 afterwards.
- `rst_i` pulsed at clear cycle 30: the clear restarts, and `ready_o` rises 64 cycles after reset release, not 34.
